// File: rtl/cpu_pkg.sv
// Shared CPU types and sizing constants.
package cpu_pkg;

  localparam int unsigned IFQ_DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the instruction fetch queue: two write ports at waddr and waddr+1,
// two asynchronous read ports at raddr and raddr+1.
module ifq_ram
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = IFQ_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr,
  input  ifq_entry_t       wdata0,
  input  ifq_entry_t       wdata1,
  input  logic [PTR_W-1:0] raddr,
  output ifq_entry_t       rdata0,
  output ifq_entry_t       rdata1
);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] waddr1;
  logic [PTR_W-1:0] raddr1;

  // Second slot wraps naturally past DEPTH-1.
  assign waddr1 = waddr + PTR_W'(1);
  assign raddr1 = raddr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling queue: accepts 1-2 instructions per fetch packet, presents up to
// two in-order head entries to dual-issue decode, and empties in one cycle on redirect.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = IFQ_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_inst_lo,
  input  logic [31:0]      push_inst_hi,
  input  logic             push_adel,
  output logic             push_ready,
  output logic             out_valid0,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_inst0,
  output logic             out_adel0,
  output logic             out_valid1,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst1,
  output logic             out_adel1,
  input  logic [1:0]       pop_cnt,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] ReadyMax = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ready_q;

  logic             push_acc;
  logic [1:0]       n_push, n_pop, avail;
  ifq_entry_t       wdata0, wdata1, rdata0, rdata1;

  always_comb begin
    push_acc = push_valid & push_ready_q & ~flush;
    n_push   = push_acc ? (push_pc[2] ? 2'd1 : 2'd2) : 2'd0;
    avail    = (count_q >= (PTR_W+1)'(2)) ? 2'd2 : count_q[1:0];
    // Over-pop is illegal; clip so the pointers never pass the write side.
    n_pop    = (pop_cnt > avail) ? avail : pop_cnt;
    count_d  = count_q + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);
  end

  always_comb begin
    wdata0.pc   = {push_pc[31:3], push_pc[2], 2'b00};
    wdata0.inst = push_pc[2] ? push_inst_hi : push_inst_lo;
    wdata0.adel = push_adel;
    wdata1.pc   = {push_pc[31:3], 3'b100};
    wdata1.inst = push_inst_hi;
    wdata1.adel = push_adel;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_ready_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_q + PTR_W'(n_push);
      rd_ptr_q     <= rd_ptr_q + PTR_W'(n_pop);
      count_q      <= count_d;
      push_ready_q <= (count_d <= ReadyMax);
    end
  end

  ifq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we0    (push_acc),
    .we1    (push_acc & ~push_pc[2]),
    .waddr  (wr_ptr_q),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr  (rd_ptr_q),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  always_comb begin
    push_ready = push_ready_q;
    count      = count_q;
    out_valid0 = (count_q != '0);
    out_valid1 = (count_q >= (PTR_W+1)'(2));
    out_pc0    = rdata0.pc;
    out_inst0  = rdata0.inst;
    out_adel0  = rdata0.adel;
    out_pc1    = rdata1.pc;
    out_inst1  = rdata1.inst;
    out_adel1  = rdata1.adel;
  end

  pop_legal_a : assert property (@(posedge clk) disable iff (rst || flush) pop_cnt <= avail);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_inst_fetch_queue;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst, flush, push_valid, push_adel, push_ready;
  logic [31:0] push_pc, push_inst_lo, push_inst_hi;
  logic        out_valid0, out_adel0, out_valid1, out_adel1;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [1:0]  pop_cnt;
  logic [4:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } m_entry_t;

  m_entry_t model_q[$];
  int       n_checks = 0;
  int       n_errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_pc      (push_pc),
    .push_inst_lo (push_inst_lo),
    .push_inst_hi (push_inst_hi),
    .push_adel    (push_adel),
    .push_ready   (push_ready),
    .out_valid0   (out_valid0),
    .out_pc0      (out_pc0),
    .out_inst0    (out_inst0),
    .out_adel0    (out_adel0),
    .out_valid1   (out_valid1),
    .out_pc1      (out_pc1),
    .out_inst1    (out_inst1),
    .out_adel1    (out_adel1),
    .pop_cnt      (pop_cnt),
    .count        (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    int sz = model_q.size();
    check_eq({tag, ".count"}, 32'(count), 32'(sz));
    check_eq({tag, ".ready"}, 32'(push_ready), 32'((D - sz) >= 2));
    check_eq({tag, ".valid0"}, 32'(out_valid0), 32'(sz >= 1));
    check_eq({tag, ".valid1"}, 32'(out_valid1), 32'(sz >= 2));
    if (sz >= 1) begin
      check_eq({tag, ".pc0"}, out_pc0, model_q[0].pc);
      check_eq({tag, ".inst0"}, out_inst0, model_q[0].inst);
      check_eq({tag, ".adel0"}, 32'(out_adel0), 32'(model_q[0].adel));
    end
    if (sz >= 2) begin
      check_eq({tag, ".pc1"}, out_pc1, model_q[1].pc);
      check_eq({tag, ".inst1"}, out_inst1, model_q[1].inst);
      check_eq({tag, ".adel1"}, 32'(out_adel1), 32'(model_q[1].adel));
    end
  endtask

  // Drive one cycle, advance the model by the documented rules, then compare after the edge.
  task automatic cycle(input string tag, input logic r, input logic fl, input logic pv,
                       input logic [31:0] pc, input logic [31:0] lo, input logic [31:0] hi,
                       input logic ad, input logic [1:0] pop);
    int       sz;
    logic     rdy;
    m_entry_t e;
    rst = r; flush = fl; push_valid = pv; push_pc = pc;
    push_inst_lo = lo; push_inst_hi = hi; push_adel = ad; pop_cnt = pop;
    sz  = model_q.size();
    rdy = (D - sz) >= 2;
    @(posedge clk);
    if (r || fl) begin
      model_q.delete();
    end else begin
      for (int i = 0; i < int'(pop); i++) model_q.delete(0);
      if (pv && rdy) begin
        if (!pc[2]) begin
          e.pc = {pc[31:3], 3'b000}; e.inst = lo; e.adel = ad;
          model_q.push_back(e);
        end
        e.pc = {pc[31:3], 3'b100}; e.inst = hi; e.adel = ad;
        model_q.push_back(e);
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    cycle("rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] lo,
                      input logic [31:0] hi, input logic ad);
    cycle(tag, 1'b0, 1'b0, 1'b1, pc, lo, hi, ad, 2'd0);
  endtask

  initial begin
    logic [31:0] prev_pc;
    int          mx;
    logic        r, fl, pv;
    logic [31:0] pc;

    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_pc = '0;
    push_inst_lo = '0; push_inst_hi = '0; push_adel = 1'b0; pop_cnt = 2'd0;

    // 1: reset state and first aligned packet
    do_reset();
    do_reset();
    check_eq("t1.rst_count", 32'(count), 32'd0);
    check_eq("t1.rst_ready", 32'(push_ready), 32'd1);
    check_eq("t1.rst_valid0", 32'(out_valid0), 32'd0);
    push("t1", 32'hbfc00000, 32'h11, 32'h22, 1'b0);
    check_eq("t1.pc0", out_pc0, 32'hbfc00000);
    check_eq("t1.pc1", out_pc1, 32'hbfc00004);
    check_eq("t1.inst1", out_inst1, 32'h22);
    check_eq("t1.count", 32'(count), 32'd2);

    // 2: odd-word packet carries only the hi instruction
    do_reset();
    push("t2", 32'hbfc00004, 32'h99, 32'h33, 1'b0);
    check_eq("t2.pc0", out_pc0, 32'hbfc00004);
    check_eq("t2.inst0", out_inst0, 32'h33);
    check_eq("t2.valid1", 32'(out_valid1), 32'd0);
    check_eq("t2.count", 32'(count), 32'd1);

    // 3: fill to 16, further pushes dropped; also the count-15 boundary
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push("t3", 32'h1000 + 32'(8 * i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
      if (i == 6) check_eq("t3.count14", 32'(count), 32'd14);
    end
    check_eq("t3.count16", 32'(count), 32'd16);
    check_eq("t3.ready16", 32'(push_ready), 32'd0);
    push("t3.drop", 32'h2000, 32'hdead, 32'hbeef, 1'b0);
    check_eq("t3.count_hold", 32'(count), 32'd16);
    do_reset();
    for (int i = 0; i < 7; i++) push("t3b", 32'h3000 + 32'(8 * i), 32'h1, 32'h2, 1'b0);
    push("t3b", 32'h3804, 32'h0, 32'h3, 1'b0);
    check_eq("t3.count15", 32'(count), 32'd15);
    check_eq("t3.ready15", 32'(push_ready), 32'd0);

    // 4: steady push 2 / pop 2 wraps the pointers
    do_reset();
    push("t4", 32'h4000, 32'h40, 32'h41, 1'b0);
    push("t4", 32'h4008, 32'h42, 32'h43, 1'b0);
    prev_pc = out_pc0;
    for (int i = 0; i < 20; i++) begin
      cycle("t4", 1'b0, 1'b0, 1'b1, 32'h4010 + 32'(8 * i), 32'(i), 32'(i + 100), 1'b0, 2'd2);
      check_eq("t4.count", 32'(count), 32'd4);
      check_eq("t4.pc0_step", out_pc0, prev_pc + 32'd8);
      check_eq("t4.pc1_step", out_pc1, out_pc0 + 32'd4);
      prev_pc = out_pc0;
    end

    // 5: flush discards contents and same-cycle push/pop
    do_reset();
    for (int i = 0; i < 3; i++) push("t5", 32'h5000 + 32'(8 * i), 32'h5, 32'h6, 1'b0);
    check_eq("t5.count6", 32'(count), 32'd6);
    cycle("t5.flush", 1'b0, 1'b1, 1'b1, 32'h6000, 32'h7, 32'h8, 1'b0, 2'd2);
    check_eq("t5.count0", 32'(count), 32'd0);
    check_eq("t5.valid0", 32'(out_valid0), 32'd0);
    check_eq("t5.ready", 32'(push_ready), 32'd1);
    push("t5.redir", 32'h80000000, 32'haa, 32'hbb, 1'b0);
    check_eq("t5.pc0", out_pc0, 32'h80000000);

    // 6: address-error tag follows its packet only
    do_reset();
    push("t6", 32'h7000, 32'h1, 32'h2, 1'b1);
    check_eq("t6.adel0", 32'(out_adel0), 32'd1);
    check_eq("t6.adel1", 32'(out_adel1), 32'd1);
    cycle("t6", 1'b0, 1'b0, 1'b1, 32'h7008, 32'h3, 32'h4, 1'b0, 2'd2);
    check_eq("t6.clean0", 32'(out_adel0), 32'd0);
    check_eq("t6.clean1", 32'(out_adel1), 32'd0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      fl = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 3) != 0);
      pc = $urandom & 32'hffff_fffc;
      mx = (model_q.size() < 2) ? model_q.size() : 2;
      cycle("rand", r, fl, pv, pc, $urandom, $urandom, 1'($urandom_range(0, 7) == 0),
            2'($urandom_range(0, mx)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
